// File: rtl/imem_fetch_ctrl_if.sv
// imem_fetch_ctrl_if: valid/ready handshake carrying {pc, instr} from fetch to decode
interface imem_fetch_ctrl_if #(parameter int ADDR_WIDTH = 64);
  logic                  valid;
  logic                  ready;
  logic [31:0]           instr;
  logic [ADDR_WIDTH-1:0] pc;
  modport master (output valid, instr, pc, input ready);
  modport slave (input valid, instr, pc, output ready);
endinterface

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: PC sequencer feeding a small {pc, instr} FIFO to decode, with redirect flush and fetch-fault trap
module imem_fetch_ctrl #(
  parameter int ADDR_WIDTH_POW = 6,
  parameter int ADDR_WIDTH = 1 << ADDR_WIDTH_POW,
  parameter int MEM_DEPTH_POW = 10,
  parameter int MEM_DEPTH = 1 << MEM_DEPTH_POW,
  parameter int FIFO_DEPTH_POW = 1,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic                  redirect_valid_in,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_in,
  output logic [ADDR_WIDTH-1:0] imem_addr_out,
  input  logic [31:0]           imem_instr_in,
  imem_fetch_ctrl_if.master     out,
  output logic                  fault_out,
  output logic [ADDR_WIDTH-1:0] fault_pc_out
);
  localparam int DEPTH = 1 << FIFO_DEPTH_POW;
  localparam logic [ADDR_WIDTH-1:0] PC_LIMIT = ADDR_WIDTH'(MEM_DEPTH) << 2;
  typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] mem_pc [DEPTH];
  logic [31:0] mem_instr [DEPTH];
  logic [FIFO_DEPTH_POW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_DEPTH_POW:0] count;
  logic fetch_ok, push, pop;
  always_comb begin
    fetch_ok = pc[1:0] == 2'b00 && pc < PC_LIMIT;
    out.valid = count != '0 && !redirect_valid_in;
    out.instr = mem_instr[rd_ptr];
    out.pc = mem_pc[rd_ptr];
    pop = out.valid && out.ready;
    push = state_q == RUN && fetch_ok && !redirect_valid_in
        && (count != (FIFO_DEPTH_POW+1)'(DEPTH) || pop);
    imem_addr_out = pc;
    fault_out = state_q == FAULT;
    state_d = redirect_valid_in ? RUN
            : (state_q == IDLE && start_in) ? RUN
            : (state_q == RUN && !fetch_ok) ? FAULT
            : state_q;
  end
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      pc <= RESET_PC;
      count <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fault_pc_out <= '0;
    end else begin
      state_q <= state_d;
      if (redirect_valid_in) begin
        pc <= redirect_pc_in;
        count <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        fault_pc_out <= '0;
      end else begin
        if (push) begin
          mem_pc[wr_ptr] <= pc;
          mem_instr[wr_ptr] <= imem_instr_in;
          wr_ptr <= wr_ptr + FIFO_DEPTH_POW'(1);
          pc <= pc + ADDR_WIDTH'(4);
        end
        if (pop) rd_ptr <= rd_ptr + FIFO_DEPTH_POW'(1);
        count <= count + (FIFO_DEPTH_POW+1)'(push) - (FIFO_DEPTH_POW+1)'(pop);
        // the faulting pc is captured only on the RUN->FAULT transition
        if (state_q == RUN && !fetch_ok) fault_pc_out <= pc;
      end
    end
  end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed vectors against a combinational instruction-memory model
module tb_imem_fetch_ctrl;
  localparam int AW = 64;
  logic clk = 0, rst = 1, start = 0, redirect = 0;
  logic [AW-1:0] redirect_pc = '0, imem_addr, fault_pc;
  logic [31:0] imem_instr;
  logic fault;
  int vectors = 0, errors = 0;
  imem_fetch_ctrl_if #(.ADDR_WIDTH(AW)) dec ();
  imem_fetch_ctrl dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .redirect_valid_in(redirect),
    .redirect_pc_in(redirect_pc), .imem_addr_out(imem_addr), .imem_instr_in(imem_instr),
    .out(dec.master), .fault_out(fault), .fault_pc_out(fault_pc)
  );
  always #5 clk = ~clk;
  assign imem_instr = 32'h1000_0000 + imem_addr[33:2];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic settle;
    #2;
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic head(input string tag, input logic [63:0] pc);
    chk({tag, " valid"}, 64'(dec.valid), 64'd1);
    chk({tag, " pc"}, dec.pc, pc);
    chk({tag, " instr"}, 64'(dec.instr), 64'(32'h1000_0000 + 32'(pc >> 2)));
  endtask
  task automatic do_reset;
    rst = 1; start = 0; redirect = 0; dec.ready = 0;
    tick; tick;
    rst = 0;
  endtask
  task automatic do_redirect(input logic [AW-1:0] target);
    redirect = 1; redirect_pc = target;
    settle;
    chk("redirect no valid", 64'(dec.valid), 64'd0);
    tick;
    redirect = 0;
  endtask
  initial begin
    dec.ready = 0;
    do_reset;
    settle;
    chk("rst valid", 64'(dec.valid), 64'd0);
    chk("rst fault", 64'(fault), 64'd0);
    chk("rst fault_pc", fault_pc, 64'd0);
    chk("rst addr", imem_addr, 64'd0);
    tick; tick; settle;
    chk("idle no fetch", 64'(dec.valid), 64'd0);
    // streaming with ready held high
    dec.ready = 1; start = 1;
    tick; start = 0; settle;
    chk("start+1 valid", 64'(dec.valid), 64'd0);
    tick; settle;
    for (int k = 0; k < 4; k++) begin
      head("stream", 64'(4 * k));
      chk("stream fault", 64'(fault), 64'd0);
      tick; settle;
    end
    // back-pressure: FIFO fills to two entries and pc stalls at 0x8
    do_reset;
    start = 1; tick; start = 0;
    for (int k = 0; k < 5; k++) tick;
    settle;
    chk("stall addr", imem_addr, 64'h8);
    head("stall head", 64'h0);
    tick; settle;
    chk("stall addr held", imem_addr, 64'h8);
    dec.ready = 1;
    for (int k = 0; k < 4; k++) begin
      settle;
      head("drain", 64'(4 * k));
      tick;
    end
    // flush of buffered 0x10/0x14 by a redirect to 0x40
    do_reset;
    do_redirect(64'h10);
    tick; tick; tick; settle;
    head("buffered", 64'h10);
    chk("buffered addr", imem_addr, 64'h18);
    dec.ready = 1;
    do_redirect(64'h40);
    settle;
    chk("redirect+1 valid", 64'(dec.valid), 64'd0);
    tick; settle;
    head("redirect+2", 64'h40);
    // misaligned target traps, then a redirect recovers
    do_redirect(64'h42);
    settle;
    chk("misalign+1 fault", 64'(fault), 64'd0);
    tick; settle;
    chk("misalign fault", 64'(fault), 64'd1);
    chk("misalign fault_pc", fault_pc, 64'h42);
    chk("misalign valid", 64'(dec.valid), 64'd0);
    tick; tick; settle;
    chk("fault held", 64'(fault), 64'd1);
    chk("fault pc held", imem_addr, 64'h42);
    do_redirect(64'h0);
    settle;
    chk("recover fault", 64'(fault), 64'd0);
    chk("recover fault_pc", fault_pc, 64'd0);
    tick; settle;
    head("recover", 64'h0);
    // run off the end of memory
    do_redirect(64'hFF0);
    tick; settle;
    for (int k = 0; k < 4; k++) begin
      head("top", 64'hFF0 + 64'(4 * k));
      tick; settle;
    end
    chk("oob fault", 64'(fault), 64'd1);
    chk("oob fault_pc", fault_pc, 64'h1000);
    chk("oob valid", 64'(dec.valid), 64'd0);
    // reset with a full FIFO
    dec.ready = 0;
    do_redirect(64'h100);
    tick; tick; tick; settle;
    head("prefull", 64'h100);
    rst = 1; tick; rst = 0; settle;
    chk("midrst valid", 64'(dec.valid), 64'd0);
    chk("midrst addr", imem_addr, 64'd0);
    chk("midrst fault", 64'(fault), 64'd0);
    dec.ready = 1;
    tick; tick; tick; settle;
    chk("midrst idle valid", 64'(dec.valid), 64'd0);
    chk("midrst idle addr", imem_addr, 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
